// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and defaults for the pipeline stall/flush control
package pipe_ctrl_pkg;

  // Data-memory handshake sequencer states
  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_st_e;

  // Architectural zero register: never a real hazard source
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default bound on cycles spent waiting for data memory
  localparam int MAX_WAIT_DEF = 15;
  localparam int WAIT_W_DEF   = 4;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare between ID and EX
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_ifid_uses_rt,
  input  logic       i_idex_mem_read,
  input  logic [4:0] i_idex_rt,
  output logic       o_load_use
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_idex_rt == i_ifid_rs);
  assign w_rt_match = i_ifid_uses_rt & (i_idex_rt == i_ifid_rt);

  // A load into $zero never produces a value, so it cannot cause a hazard
  assign o_load_use = i_idex_mem_read & (i_idex_rt != REG_ZERO) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline (optional HAZ_PERF_CNT_EN)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAIT_W   = WAIT_W_DEF
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int PERF_W   = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  input  logic       ifid_uses_rt_i,
  input  logic       idex_mem_read_i,
  input  logic [4:0] idex_rt_i,
  input  logic       branch_taken_i,
  input  logic       exmem_mem_read_i,
  input  logic       exmem_mem_write_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       ifid_flush_o,
  output logic       idex_write_o,
  output logic       idex_bubble_o,
  output logic       exmem_write_o,
  output logic       memwb_bubble_o,
  output logic       mem_req_o,
  output logic       timeout_err_o
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_mem_stall_o,
  output logic [PERF_W-1:0] perf_lu_stall_o
`endif
);

  localparam logic [WAIT_W-1:0] W_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] W_SAT = {WAIT_W{1'b1}};

  mem_st_e           r_st;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_timeout_err;

  logic w_mem_op;
  logic w_load_use;
  logic w_mem_stall;
  logic w_abort;

  assign w_mem_op      = exmem_mem_read_i | exmem_mem_write_i;
  assign timeout_err_o = r_timeout_err;

  hazard_detect u_hazard_detect (
    .i_ifid_rs       (ifid_rs_i),
    .i_ifid_rt       (ifid_rt_i),
    .i_ifid_uses_rt  (ifid_uses_rt_i),
    .i_idex_mem_read (idex_mem_read_i),
    .i_idex_rt       (idex_rt_i),
    .o_load_use      (w_load_use)
  );

  // Memory handshake decode: request, stall and timeout-abort for this cycle
  always_comb begin
    mem_req_o   = 1'b0;
    w_mem_stall = 1'b0;
    w_abort     = 1'b0;
    if (!rst) begin
      if (r_st == M_IDLE) begin
        mem_req_o   = w_mem_op;
        w_mem_stall = w_mem_op & ~mem_ready_i;
      end else begin
        mem_req_o   = 1'b1;
        w_abort     = ~mem_ready_i & (r_wait_cnt == W_MAX);
        w_mem_stall = ~mem_ready_i & ~w_abort;
      end
    end
  end

  // Priority mux: memory stall, then timeout abort, then branch flush, then load-use bubble
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b1;
    idex_bubble_o  = 1'b0;
    exmem_write_o  = 1'b1;
    memwb_bubble_o = 1'b0;
    if (rst) begin
      pc_write_o = 1'b1;
    end else if (w_mem_stall) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (w_abort) begin
      // Dropped access must not write back; a taken branch still squashes ID
      memwb_bubble_o = 1'b1;
      ifid_flush_o   = branch_taken_i;
      idex_bubble_o  = branch_taken_i;
    end else if (branch_taken_i) begin
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else if (w_load_use) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end
  end

  // Handshake FSM with saturating wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st          <= M_IDLE;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else if (r_st == M_IDLE) begin
      if (w_mem_op && !mem_ready_i) begin
        r_st       <= M_WAIT;
        r_wait_cnt <= WAIT_W'(1);
      end
    end else begin
      if (mem_ready_i) begin
        r_st <= M_IDLE;
      end else if (r_wait_cnt == W_MAX) begin
        r_timeout_err <= 1'b1;
        r_st          <= M_IDLE;
      end else if (r_wait_cnt != W_SAT) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic              w_lu_stall;
  logic [PERF_W-1:0] r_perf_mem;
  logic [PERF_W-1:0] r_perf_lu;

  assign w_lu_stall       = ~rst & ~w_mem_stall & ~w_abort & ~branch_taken_i & w_load_use;
  assign perf_mem_stall_o = r_perf_mem;
  assign perf_lu_stall_o  = r_perf_lu;

  // Free-running stall counters, wrapping naturally at their width
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_mem <= '0;
      r_perf_lu  <= '0;
    end else begin
      if (w_mem_stall) r_perf_mem <= r_perf_mem + PERF_W'(1);
      if (w_lu_stall)  r_perf_lu  <= r_perf_lu + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl against a behavioural model
module tb_pipe_hazard_ctrl;

  localparam int MAXW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       uses_rt, idex_mr, br, ex_rd, ex_wr, rdy;
  logic       pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, req, err;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_ms, perf_lu;
`endif

  pipe_hazard_ctrl #(.MAX_WAIT(MAXW), .WAIT_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .ifid_rs_i         (ifid_rs),
    .ifid_rt_i         (ifid_rt),
    .ifid_uses_rt_i    (uses_rt),
    .idex_mem_read_i   (idex_mr),
    .idex_rt_i         (idex_rt),
    .branch_taken_i    (br),
    .exmem_mem_read_i  (ex_rd),
    .exmem_mem_write_i (ex_wr),
    .mem_ready_i       (rdy),
    .pc_write_o        (pc_w),
    .ifid_write_o      (ifid_w),
    .ifid_flush_o      (ifid_f),
    .idex_write_o      (idex_w),
    .idex_bubble_o     (idex_b),
    .exmem_write_o     (exmem_w),
    .memwb_bubble_o    (memwb_b),
    .mem_req_o         (req),
    .timeout_err_o     (err)
`ifdef HAZ_PERF_CNT_EN
    ,
    .perf_mem_stall_o  (perf_ms),
    .perf_lu_stall_o   (perf_lu)
`endif
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: number of consecutive cycles the outstanding access has stalled
  int m_stalled = 0;
  bit m_err = 0;
  int m_ms = 0;
  int m_lu = 0;
  bit e_stall, e_abort, e_lu;

  // outputs sampled at the last negedge
  logic [8:0] s_out;
  logic s_pc, s_ifid_w, s_ifid_f, s_idex_b, s_exmem_w, s_memwb_b, s_req, s_err;

  function automatic logic [8:0] expect_out();
    bit mem_op, lu, pend;
    bit x_pc, x_ifw, x_iff, x_idw, x_idb, x_exw, x_mwb, x_req;
    mem_op = ex_rd | ex_wr;
    lu = idex_mr && (idex_rt != 5'd0) && ((idex_rt == ifid_rs) || (uses_rt && (idex_rt == ifid_rt)));
    pend = (m_stalled > 0);
    x_req = 0; e_stall = 0; e_abort = 0;
    if (!rst) begin
      if (pend) begin
        x_req = 1;
        if (!rdy) begin
          if (m_stalled >= MAXW) e_abort = 1;
          else e_stall = 1;
        end
      end else begin
        x_req = mem_op;
        e_stall = mem_op && !rdy;
      end
    end
    x_pc = 1; x_ifw = 1; x_iff = 0; x_idw = 1; x_idb = 0; x_exw = 1; x_mwb = 0;
    if (rst) begin
      x_pc = 1;
    end else if (e_stall) begin
      x_pc = 0; x_ifw = 0; x_idw = 0; x_exw = 0; x_mwb = 1;
    end else if (e_abort) begin
      x_mwb = 1; x_iff = br; x_idb = br;
    end else if (br) begin
      x_iff = 1; x_idb = 1;
    end else if (lu) begin
      x_pc = 0; x_ifw = 0; x_idb = 1;
    end
    e_lu = !rst && !e_stall && !e_abort && !br && lu;
    return {x_pc, x_ifw, x_iff, x_idw, x_idb, x_exw, x_mwb, x_req, m_err};
  endfunction

  task automatic check();
    logic [8:0] exp_v;
    exp_v = expect_out();
    s_out = {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, req, err};
    {s_pc, s_ifid_w, s_ifid_f} = {pc_w, ifid_w, ifid_f};
    {s_idex_b, s_exmem_w, s_memwb_b, s_req, s_err} = {idex_b, exmem_w, memwb_b, req, err};
    total++;
    if (s_out !== exp_v) begin
      bad++;
      $display("FAIL outs cyc=%0d got=%b exp=%b (pc,ifw,iff,idw,idb,exw,mwb,req,err)", cyc, s_out, exp_v);
    end
`ifdef HAZ_PERF_CNT_EN
    total++;
    if (perf_ms !== 32'(m_ms) || perf_lu !== 32'(m_lu)) begin
      bad++;
      $display("FAIL perf cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, perf_ms, perf_lu, m_ms, m_lu);
    end
`endif
  endtask

  task automatic model_update();
    if (rst) begin
      m_stalled = 0; m_err = 0; m_ms = 0; m_lu = 0;
    end else begin
      if (e_abort) m_err = 1;
      if (e_stall) begin m_stalled++; m_ms++; end
      else m_stalled = 0;
      if (e_lu) m_lu++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic lit(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp_v);
    end
  endtask

  task automatic quiet();
    rst = 0; ifid_rs = 0; ifid_rt = 0; idex_rt = 0; uses_rt = 0;
    idex_mr = 0; br = 0; ex_rd = 0; ex_wr = 0; rdy = 0;
  endtask

  initial begin
    int n_stall, n_req, n_abort;
    quiet();
    rst = 1;
    @(posedge clk); #1;
    step();
    lit("reset_req", int'(s_req), 0);
    lit("reset_pc", int'(s_pc), 1);
    lit("reset_err", int'(s_err), 0);
    quiet();
    step();

    // load-use single bubble
    idex_mr = 1; idex_rt = 8; ifid_rs = 8;
    step();
    lit("lu_pc", int'(s_pc), 0);
    lit("lu_ifid_w", int'(s_ifid_w), 0);
    lit("lu_idex_b", int'(s_idex_b), 1);
    idex_rt = 0; ifid_rs = 0;
    step();
    lit("lu_zero_pc", int'(s_pc), 1);
    lit("lu_zero_idex_b", int'(s_idex_b), 0);
    quiet();

    // memory wait of 3 cycles
    n_stall = 0; n_req = 0;
    ex_rd = 1;
    for (int i = 0; i < 4; i++) begin
      rdy = (i == 3);
      step();
      n_stall += int'(!s_exmem_w && s_memwb_b);
      n_req += int'(s_req);
    end
    lit("wait_stalls", n_stall, 3);
    lit("wait_reqs", n_req, 4);
    quiet();
    step();
    lit("wait_back_idle", int'(s_req), 0);

    // zero-latency store
    ex_wr = 1; rdy = 1;
    step();
    lit("zl_req", int'(s_req), 1);
    lit("zl_exmem_w", int'(s_exmem_w), 1);
    quiet();
    step();
    lit("zl_idle", int'(s_req), 0);

    // simultaneous stall, branch and load-use
    ex_rd = 1; rdy = 0; br = 1; idex_mr = 1; idex_rt = 8; ifid_rs = 8;
    step();
    lit("sim_flush", int'(s_ifid_f), 0);
    lit("sim_exmem_w", int'(s_exmem_w), 0);
    rdy = 1;
    step();
    lit("sim_after_flush", int'(s_ifid_f), 1);
    lit("sim_after_pc", int'(s_pc), 1);
    quiet();
    step();

    // timeout: memory never answers
    n_stall = 0; n_abort = 0;
    ex_rd = 1; rdy = 0;
    for (int i = 0; i < 20 && n_abort == 0; i++) begin
      step();
      if (s_memwb_b && s_exmem_w) n_abort = 1;
      else if (!s_exmem_w) n_stall++;
    end
    lit("to_abort_seen", n_abort, 1);
    lit("to_stalls", n_stall, MAXW);
    ex_rd = 0;
    step();
    lit("to_err_set", int'(s_err), 1);
    step(); step();
    lit("to_err_sticky", int'(s_err), 1);
    rst = 1;
    step();
    rst = 0;
    step();
    lit("to_err_cleared", int'(s_err), 0);

    // reset in the middle of a wait
    ex_rd = 1; rdy = 0;
    step(); step();
    rst = 1;
    step();
    quiet();
    step();
    lit("rstw_req", int'(s_req), 0);
    lit("rstw_err", int'(s_err), 0);
`ifdef HAZ_PERF_CNT_EN
    lit("rstw_perf_ms", int'(perf_ms), 0);
    lit("rstw_perf_lu", int'(perf_lu), 0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      ifid_rs = 5'($urandom_range(0, 3));
      ifid_rt = 5'($urandom_range(0, 3));
      idex_rt = 5'($urandom_range(0, 3));
      uses_rt = 1'($urandom_range(0, 1));
      idex_mr = 1'($urandom_range(0, 1));
      br      = ($urandom_range(0, 7) == 0);
      ex_rd   = ($urandom_range(0, 3) == 0);
      ex_wr   = ($urandom_range(0, 5) == 0);
      rdy     = (i % 500 < 40) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
